// File: rtl/adder_serial_cla_64bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_serial_cla_64bit
// Description : 64-bit adder that works on one 16-bit slice per clock using
//               two-level 4-bit carry lookahead inside the slice. Operands are
//               taken with a valid/ready handshake, and the result is held
//               until the consumer takes it.
//               Optional macro ADDER_SUB_EN adds a 'sub' port for a-b.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_serial_cla_64bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
`ifdef ADDER_SUB_EN
    input  logic        sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic [63:0] r_a;
    logic [63:0] r_b;

    logic [15:0] w_a_sl;
    logic [15:0] w_b_sl;
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;          // carry into each bit of the slice
    logic [15:0] w_s;
    logic [3:0]  w_gg;         // group generate
    logic [3:0]  w_gp;         // group propagate
    logic [3:0]  w_gc;         // carry into each 4-bit group
    logic        w_slice_cout;
    logic [63:0] w_b_eff;
    logic        w_cin_eff;

    // Operand B and initial carry as latched on acceptance
`ifdef ADDER_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    assign in_ready = (r_state == IDLE);

    assign w_a_sl = r_a[{r_idx, 4'b0000} +: 16];
    assign w_b_sl = r_b[{r_idx, 4'b0000} +: 16];
    assign w_p    = w_a_sl ^ w_b_sl;
    assign w_g    = w_a_sl & w_b_sl;

    // Second-level lookahead: carries between groups come straight from the
    // group G/P terms and the slice carry-in, not from rippling.
    assign w_gc[0] = r_carry;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & r_carry);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & r_carry);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & r_carry);
    assign w_slice_cout = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                        | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                        | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & r_carry);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            logic [3:0] p4;
            logic [3:0] g4;
            logic       c0;
            assign p4 = w_p[4*k +: 4];
            assign g4 = w_g[4*k +: 4];
            assign c0 = w_gc[k];

            assign w_gg[k] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                           | (p4[3] & p4[2] & p4[1] & g4[0]);
            assign w_gp[k] = &p4;

            // First-level lookahead inside the group
            assign w_c[4*k]     = c0;
            assign w_c[4*k + 1] = g4[0] | (p4[0] & c0);
            assign w_c[4*k + 2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
            assign w_c[4*k + 3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                                | (p4[2] & p4[1] & p4[0] & c0);
        end
    endgenerate

    assign w_s = w_p ^ w_c;

    // Control FSM, slice sequencing and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_carry   <= 1'b0;
            r_a       <= 64'd0;
            r_b       <= 64'd0;
            sum       <= 64'd0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= 2'd0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    sum[{r_idx, 4'b0000} +: 16] <= w_s;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        // w_c[15] is the carry into bit 63 on the last slice
                        cout      <= w_slice_cout;
                        ovf       <= w_c[15] ^ w_slice_cout;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/adder_serial_cla_64bit.md
ADDER_SERIAL_CLA_64BIT -- requirements
Module: adder_serial_cla_64bit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 64 bits, processed as four 16-bit slices.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  64  operand A.
REQ-007 b  input  64  operand B.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 sub  input  1  subtract request; present only when ADDER_SUB_EN is defined.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  64  result.
REQ-013 cout  output  1  carry out of bit 63.
REQ-014 ovf  output  1  signed overflow, i.e. carry into bit 63 XOR cout.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE, held in a state register.
REQ-016 in_ready SHALL be 1 in IDLE and 0 in all other states, decoded from the state register only.
REQ-017 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1; that edge latches a, b and cin (and sub), clears the slice index to 0, and moves IDLE->CALC.
REQ-018 In CALC, each edge SHALL process slice idx (bits 16*idx+15..16*idx):
- p = a^b and g = a&b of the slice;
- per-bit carries from 4-bit group lookahead;
- the slice carry-in is the running carry register (latched cin for idx 0);
- sum slice is written, running carry takes the slice carry-out, and idx increments.
REQ-019 The edge processing idx=3 SHALL move CALC->DONE and capture cout and ovf.
REQ-020 Latency SHALL be fixed: out_valid rises exactly 4 edges after the acceptance edge.
REQ-021 In DONE, out_valid SHALL be 1 and sum, cout and ovf SHALL be held stable until the handshake.
REQ-022 DONE with out_ready=1 on an edge SHALL move to IDLE; out_valid falls on that edge, and the outputs keep their last values.
REQ-023 The earliest next acceptance SHALL be the edge after the return to IDLE, giving a peak throughput of one operation per 6 cycles.
REQ-024 in_valid, a, b and cin changes outside IDLE SHALL be ignored, with no corruption of the operation in flight.
REQ-025 Carries SHALL wrap: the 64-bit sum is taken modulo 2^64, and the excess is reported only via cout.
REQ-026 out_ready while not in DONE SHALL have no effect.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE, idx=0 and running carry=0, and SHALL set sum=0, cout=0, ovf=0 and out_valid=0; in_ready is 1 after that edge.
REQ-028 Reset mid-CALC or in DONE SHALL abandon the operation without emitting out_valid.
REQ-029 Reset SHALL take priority over any simultaneous in_valid or out_ready.

Configuration
REQ-030 The macro ADDER_SUB_EN SHALL control subtraction support, as follows.
- Defined: the sub port exists. sub=1 at acceptance latches ~b as operand B and forces the initial carry to 1 (cin is ignored), giving a-b. cout=1 then means no borrow, and ovf is signed overflow of the subtraction.
- Undefined: the sub port is absent and the block only adds.

Verification
REQ-031 Reset, then a=64'h0000_0000_0000_0001, b=64'h0000_0000_0000_0002, cin=0 -> out_valid exactly 4 edges after acceptance, sum=64'h3, cout=0, ovf=0.
REQ-032 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0; this exercises carry across all three slice boundaries.
REQ-033 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE and toggle a/b/in_valid meanwhile -> out_valid stays 1 and sum stays unchanged. Then out_ready=1 -> IDLE, and the next operation is accepted the following edge.
REQ-035 Assert rst after 2 CALC edges -> out_valid never rises, and the next edge shows in_ready=1, sum=0, cout=0, ovf=0.
REQ-036 With ADDER_SUB_EN defined: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also a=7, b=5, sub=1 -> sum=2, cout=1.
